// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and LSU results onto one register-file write port
// and tracks pending destination registers. Define WB_RR_EN for round-robin arbitration.
module wb_arbiter #(
    localparam int unsigned RW = 5,
    localparam int unsigned DW = 32,
    localparam int unsigned NR = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    input  logic [RW-1:0] alu_rd,
    input  logic [DW-1:0] alu_wd,
    output logic          alu_ready,
    input  logic          lsu_valid,
    input  logic [RW-1:0] lsu_rd,
    input  logic [DW-1:0] lsu_wd,
    output logic          lsu_ready,
    output logic          rf_we,
    output logic [RW-1:0] rf_rd,
    output logic [DW-1:0] rf_wd,
    input  logic          iss_set,
    input  logic [RW-1:0] iss_rd,
    input  logic [RW-1:0] q_rs1,
    input  logic [RW-1:0] q_rs2,
    output logic          q_busy1,
    output logic          q_busy2
);

    logic          w_alu_gnt;
    logic          w_lsu_gnt;
    logic          w_xfer;
    logic          w_wr;
    logic [RW-1:0] w_rd;
    logic [DW-1:0] w_wd;
    logic [NR-1:0] r_busy;
    logic [NR-1:0] w_busy_nxt;

`ifdef WB_RR_EN
    // High when the LSU should win the next contended cycle.
    logic r_lsu_next;

    always_comb begin
        w_alu_gnt = alu_valid && !(lsu_valid && r_lsu_next);
        w_lsu_gnt = lsu_valid && !(alu_valid && !r_lsu_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lsu_next <= 1'b0;
        end else if (w_alu_gnt) begin
            r_lsu_next <= 1'b1;
        end else if (w_lsu_gnt) begin
            r_lsu_next <= 1'b0;
        end
    end
`else
    always_comb begin
        w_lsu_gnt = lsu_valid;
        w_alu_gnt = alu_valid && !lsu_valid;
    end
`endif

    // Grant is combinational; the winner's payload is muxed onto the write port.
    always_comb begin
        alu_ready = w_alu_gnt;
        lsu_ready = w_lsu_gnt;
        w_xfer    = w_alu_gnt || w_lsu_gnt;
        w_rd      = w_lsu_gnt ? lsu_rd : alu_rd;
        w_wd      = w_lsu_gnt ? lsu_wd : alu_wd;
        w_wr      = w_xfer && (w_rd != RW'(0));
    end

    // Writes to x0 are consumed silently; rd/wd keep the last real write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_rd <= RW'(0);
            rf_wd <= DW'(0);
        end else begin
            rf_we <= w_wr;
            if (w_wr) begin
                rf_rd <= w_rd;
                rf_wd <= w_wd;
            end
        end
    end

    // Clear on completed write, then set on issue so a same-index issue wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (rf_we) begin
            w_busy_nxt[rf_rd] = 1'b0;
        end
        if (iss_set) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= NR'(0);
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        q_busy1 = r_busy[q_rs1];
        q_busy2 = r_busy[q_rs2];
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_wd = '0;
    logic        alu_ready;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_wd = '0;
    logic        lsu_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        iss_set = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic [4:0]  q_rs1 = '0;
    logic [4:0]  q_rs2 = '0;
    logic        q_busy1;
    logic        q_busy2;

    int errors = 0;
    int checks = 0;

    wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
        .iss_set(iss_set), .iss_rd(iss_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_busy1(q_busy1), .q_busy2(q_busy2)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit        m_busy [32];
    bit        m_we;
    bit [4:0]  m_rd;
    bit [31:0] m_wd;
    bit        m_last_lsu;   // who won the last grant; reset means ALU is favoured
    bit        t_ga, t_gl;   // grants of the most recent tick

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_we = 1'b0;
        m_rd = '0;
        m_wd = '0;
        m_last_lsu = 1'b1;
    endfunction

    function automatic void predict(output bit ga, output bit gl);
        ga = 1'b0;
        gl = 1'b0;
        if (alu_valid && lsu_valid) begin
`ifdef WB_RR_EN
            if (m_last_lsu) ga = 1'b1; else gl = 1'b1;
`else
            gl = 1'b1;
`endif
        end else begin
            ga = alu_valid;
            gl = lsu_valid;
        end
    endfunction

    // Advance one clock: evaluate the model on the pre-edge inputs, then sample at edge+1.
    task automatic tick();
        bit        nb [32];
        bit [4:0]  rd;
        bit [31:0] wd;
        predict(t_ga, t_gl);
        if (rst_n) begin
            nb = m_busy;
            if (m_we) nb[m_rd] = 1'b0;
            if (iss_set && iss_rd != 5'd0) nb[iss_rd] = 1'b1;
            m_we = 1'b0;
            if (t_ga || t_gl) begin
                m_last_lsu = t_gl;
                rd = t_ga ? alu_rd : lsu_rd;
                wd = t_ga ? alu_wd : lsu_wd;
                if (rd != 5'd0) begin
                    m_we = 1'b1;
                    m_rd = rd;
                    m_wd = wd;
                end
            end
            m_busy = nb;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        iss_set   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        q_rs1 = 5'd1;
        q_rs2 = 5'd2;
        tick();
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wd !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%0b rd=%0d wd=%08h required 0/0/0", rf_we, rf_rd, rf_wd);
        end
        checks++;
        if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %0b%0b required 00", q_busy1, q_busy2);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_single();
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_wd    = 32'hDEADBEEF;
        #2;
        checks++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL alu_single_ready: got alu=%0b lsu=%0b required 1/0", alu_ready, lsu_ready);
        end
        tick();
        alu_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL alu_single_write: got we=%0b rd=%0d wd=%08h required 1/5/deadbeef", rf_we, rf_rd, rf_wd);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL alu_single_hold: got we=%0b rd=%0d wd=%08h required 0/5/deadbeef", rf_we, rf_rd, rf_wd);
        end
    endtask

    task automatic test_contention();
        bit exp_alu;
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_wd = 32'hA1A1_0001;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_wd = 32'hB2B2_0002;
        for (int i = 0; i < 4; i++) begin
`ifdef WB_RR_EN
            exp_alu = (i % 2 == 0);
`else
            exp_alu = 1'b0;
`endif
            #2;
            checks++;
            if (alu_ready !== exp_alu || lsu_ready !== !exp_alu) begin
                errors++;
                $display("FAIL contention_grant%0d: got alu=%0b lsu=%0b required alu=%0b lsu=%0b",
                         i, alu_ready, lsu_ready, exp_alu, !exp_alu);
            end
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_rd !== (exp_alu ? 5'd1 : 5'd2)) begin
                errors++;
                $display("FAIL contention_write%0d: got we=%0b rd=%0d required 1/%0d",
                         i, rf_we, rf_rd, exp_alu ? 1 : 2);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_rd_zero();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'h0000_1234;
        #2;
        checks++;
        if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd0_ready: got lsu=%0b alu=%0b required 1/0", lsu_ready, alu_ready);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL rd0_no_write: got we=%0b required 0", rf_we);
        end
        alu_valid = 1'b1; alu_rd = 5'd9;  alu_wd = 32'h0909_0909;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_wd = 32'h1010_1010;
        #2;
        checks++;
`ifdef WB_RR_EN
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd0_history: got alu=%0b lsu=%0b required 1/0", alu_ready, lsu_ready);
        end
`else
        if (alu_ready !== 1'b0 || lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd0_history: got alu=%0b lsu=%0b required 0/1", alu_ready, lsu_ready);
        end
`endif
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_scoreboard();
        q_rs1 = 5'd7;
        iss_set = 1'b1; iss_rd = 5'd7;
        #2;
        checks++;
        if (q_busy1 !== 1'b0) begin
            errors++;
            $display("FAIL sb_no_forward: got %0b required 0", q_busy1);
        end
        tick();
        iss_set = 1'b0;
        #1;
        checks++;
        if (q_busy1 !== 1'b1) begin
            errors++;
            $display("FAIL sb_set: got %0b required 1", q_busy1);
        end
        alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'h7777_7777;
        tick();
        alu_valid = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b1 || q_busy1 !== 1'b1) begin
            errors++;
            $display("FAIL sb_during_write: got we=%0b busy=%0b required 1/1", rf_we, q_busy1);
        end
        tick();
        checks++;
        if (q_busy1 !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear: got %0b required 0", q_busy1);
        end
        iss_set = 1'b1; iss_rd = 5'd7;
        tick();
        iss_set = 1'b0;
        alu_valid = 1'b1;
        tick();
        alu_valid = 1'b0;
        iss_set = 1'b1; iss_rd = 5'd7;   // re-issue in the rf_we cycle
        tick();
        iss_set = 1'b0;
        #1;
        checks++;
        if (q_busy1 !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_wins: got %0b required 1", q_busy1);
        end
        iss_set = 1'b1; iss_rd = 5'd0; q_rs1 = 5'd0;
        tick();
        iss_set = 1'b0;
        #1;
        checks++;
        if (q_busy1 !== 1'b0) begin
            errors++;
            $display("FAIL sb_x0: got %0b required 0", q_busy1);
        end
    endtask

    task automatic test_reset_mid();
        iss_set = 1'b1; iss_rd = 5'd3; q_rs2 = 5'd3;
        tick();
        iss_set = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_wd = $urandom;
        tick();
        alu_wd = $urandom;
        alu_rd = 5'd6;
        tick();
        #2;
        checks++;
        if (q_busy2 !== 1'b1 || rf_we !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got busy3=%0b we=%0b required 1/1", q_busy2, rf_we);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wd !== 32'd0 || q_busy2 !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: got we=%0b rd=%0d wd=%08h busy3=%0b required 0/0/0/0",
                     rf_we, rf_rd, rf_wd, q_busy2);
        end
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_ready_in_reset: got %0b required 1", alu_ready);
        end
        tick();
        idle_inputs();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rf_we !== 1'b0) begin
                errors++;
                $display("FAIL mid_release%0d: got we=%0b required 0", i, rf_we);
            end
        end
    endtask

    task automatic test_random();
        bit ga, gl;
        bit alu_take = 1'b1, lsu_take = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!alu_valid || alu_take) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_wd    = $urandom;
            end
            if (!lsu_valid || lsu_take) begin
                lsu_valid = ($urandom_range(0, 2) != 0);
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_wd    = $urandom;
            end
            iss_set = ($urandom_range(0, 2) == 0);
            iss_rd  = 5'($urandom_range(0, 7));
            q_rs1   = 5'($urandom_range(0, 7));
            q_rs2   = 5'($urandom_range(0, 7));
            #2;
            predict(ga, gl);
            checks++;
            if (alu_ready !== ga || lsu_ready !== gl) begin
                errors++;
                $display("FAIL rnd_grant c%0d: got alu=%0b lsu=%0b required %0b/%0b", c, alu_ready, lsu_ready, ga, gl);
            end
            checks++;
            if (q_busy1 !== m_busy[q_rs1] || q_busy2 !== m_busy[q_rs2]) begin
                errors++;
                $display("FAIL rnd_busy c%0d: got %0b%0b required %0b%0b",
                         c, q_busy1, q_busy2, m_busy[q_rs1], m_busy[q_rs2]);
            end
            tick();
            alu_take = t_ga;
            lsu_take = t_gl;
            checks++;
            if (rf_we !== m_we || (m_we && (rf_rd !== m_rd || rf_wd !== m_wd))) begin
                errors++;
                $display("FAIL rnd_write c%0d: got we=%0b rd=%0d wd=%08h required %0b/%0d/%08h",
                         c, rf_we, rf_rd, rf_wd, m_we, m_rd, m_wd);
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_contention();
        test_rd_zero();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL use one clock and one reset: clk, input, 1, rising-edge clock; rst_n, input, 1, asynchronous active-low reset.
REQ-002 alu_valid/alu_rd/alu_wd SHALL be inputs, 1/5/32 bits, ALU write-back request, destination and data.
REQ-003 alu_ready SHALL be an output, 1 bit, ALU request accepted this cycle.
REQ-004 lsu_valid/lsu_rd/lsu_wd SHALL be inputs, 1/5/32 bits, load-unit write-back request, destination and data.
REQ-005 lsu_ready SHALL be an output, 1 bit, LSU request accepted this cycle.
REQ-006 rf_we/rf_rd/rf_wd SHALL be outputs, 1/5/32 bits, registered drive of the register file's single write port (we, rd, wd).
REQ-007 iss_set/iss_rd SHALL be inputs, 1/5 bits, issue stage marks iss_rd pending.
REQ-008 q_rs1/q_rs2 SHALL be inputs, 5 bits each; q_busy1/q_busy2 SHALL be outputs, 1 bit each, pending status of the queried registers.

Function
REQ-009 Grant SHALL be combinational: at most one of alu_ready/lsu_ready high per cycle; a ready SHALL only be high while the matching valid is high.
REQ-010 Single requester valid SHALL be granted the same cycle.
REQ-011 A transfer is valid&&ready in cycle N; rf_we/rf_rd/rf_wd SHALL reflect it in cycle N+1, rf_we high exactly one cycle per transfer.
REQ-012 No transfer in cycle N SHALL give rf_we=0 in N+1; rf_rd/rf_wd SHALL hold their previous values.
REQ-013 A transfer with rd=0 SHALL be accepted (ready high) but SHALL NOT raise rf_we; it still counts as a grant for arbitration history.
REQ-014 Throughput SHALL be one transfer per cycle with no bubbles under back-to-back requests.
REQ-015 Scoreboard busy[31:0]: iss_set with iss_rd!=0 SHALL set busy[iss_rd] at the next edge; busy[0] SHALL always read 0.
REQ-016 A cycle with rf_we=1 SHALL clear busy[rf_rd] at that cycle's closing edge.
REQ-017 Simultaneous set and clear of the same index SHALL leave the bit set (new issue wins).
REQ-018 q_busyN SHALL equal busy[q_rsN] combinationally, with no forwarding of same-cycle iss_set or rf_we.
REQ-019 Requesters SHALL hold valid/rd/wd stable until accepted; the block SHALL NOT buffer more than the single output register.

Reset
REQ-020 rst_n low SHALL immediately force rf_we=0, rf_rd=0, rf_wd=0, busy=0, and the arbitration pointer to "ALU next"; readies SHALL remain functions of valids.
REQ-021 A transfer accepted in the cycle reset asserts SHALL be discarded; no rf_we SHALL follow reset release without a new transfer.

Configuration
REQ-022 Macro WB_RR_EN defined: contention SHALL be resolved round-robin; a one-bit pointer SHALL favour the requester not granted last and SHALL update on every grant.
REQ-023 WB_RR_EN undefined: contention SHALL be fixed-priority, LSU wins; the pointer SHALL be absent; all other behaviour identical.

Verification
REQ-024 Reset, then ALU only, rd=5, wd=0xDEADBEEF -> alu_ready same cycle; next cycle rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF; following cycle rf_we=0.
REQ-025 Both valid for 4 cycles (ALU rd=1, LSU rd=2), WB_RR_EN on -> grants ALU,LSU,ALU,LSU; off -> LSU every cycle, alu_ready never high.
REQ-026 LSU rd=0, wd=0x1234 -> lsu_ready=1, rf_we stays 0 next cycle; with WB_RR_EN, next contention grants ALU.
REQ-027 iss_set rd=7, then q_rs1=7 -> q_busy1=1; ALU writes rd=7 -> q_busy1=0 the cycle after rf_we; iss_set rd=7 in the rf_we cycle -> q_busy1 stays 1.
REQ-028 iss_set rd=0 -> q_busy1=0 for q_rs1=0; rst_n pulsed low mid-burst with busy[3]=1 -> rf_we=0, busy all 0 immediately, no rf_we after release until a new request.
